// File: rtl/ex_arith_unit.sv
// ex_arith_unit: execute-stage arithmetic block.
// Registers pc+4, the branch target and an 8-op ALU result with its signed
// overflow flag. zero is decoded from the registered ALU result, so it needs
// no flop of its own.
module ex_arith_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] base,
   input  logic [WIDTH-1:0] offset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       opcode,
   output logic [WIDTH-1:0] pc_plus4,
   output logic [WIDTH-1:0] branch_target,
   output logic [WIDTH-1:0] alu_out,
   output logic             zero,
   output logic             overflow
);

   typedef enum logic [2:0] {
      OP_AND = 3'b000,
      OP_OR  = 3'b001,
      OP_ADD = 3'b010,
      OP_XOR = 3'b011,
      OP_NOR = 3'b100,
      OP_ZRO = 3'b101,
      OP_SUB = 3'b110,
      OP_SLT = 3'b111
   } op_e;

   logic [WIDTH-1:0] pc_plus4_d, pc_plus4_q;
   logic [WIDTH-1:0] branch_target_d, branch_target_q;
   logic [WIDTH-1:0] alu_out_d, alu_out_q;
   logic             overflow_d, overflow_q;
   logic [WIDTH-1:0] sum, diff;
   logic             slt;

   // Next-state datapath: address adders plus the ALU op select.
   always_comb begin
      sum  = a + b;
      diff = a - b;
      // Direct signed compare, so SLT stays correct when a-b overflows.
      slt  = $signed(a) < $signed(b);

      // Carry-outs are dropped by the fixed-width adds.
      pc_plus4_d      = pc + WIDTH'(4);
      // Word offset becomes a byte offset; the top two offset bits fall off.
      branch_target_d = base + {offset[WIDTH-3:0], 2'b00};

      alu_out_d  = '0;
      overflow_d = 1'b0;
      case (op_e'(opcode))
         OP_AND: alu_out_d = a & b;
         OP_OR:  alu_out_d = a | b;
         OP_ADD: begin
            alu_out_d  = sum;
            // Same-sign operands producing a different-sign result.
            overflow_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_XOR: alu_out_d = a ^ b;
         OP_NOR: alu_out_d = ~(a | b);
         OP_ZRO: alu_out_d = '0;
         OP_SUB: begin
            alu_out_d  = diff;
            // Opposite-sign operands with the result sign flipped away from a.
            overflow_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLT: alu_out_d = {{(WIDTH-1){1'b0}}, slt};
         default: alu_out_d = '0;
      endcase
   end

   // Output registers: async clear, load on en, otherwise hold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_plus4_q      <= '0;
         branch_target_q <= '0;
         alu_out_q       <= '0;
         overflow_q      <= 1'b0;
      end else if (en) begin
         pc_plus4_q      <= pc_plus4_d;
         branch_target_q <= branch_target_d;
         alu_out_q       <= alu_out_d;
         overflow_q      <= overflow_d;
      end
   end

   assign pc_plus4      = pc_plus4_q;
   assign branch_target = branch_target_q;
   assign alu_out       = alu_out_q;
   assign overflow      = overflow_q;
   assign zero          = (alu_out_q == '0);

endmodule

// File: tb/tb_ex_arith_unit.sv
// Scoreboard bench for ex_arith_unit: the driver pushes a model-computed
// expectation for every enabled edge, the monitor pops one per loading edge
// and compares every output one time unit after each rising clock.
module tb_ex_arith_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [31:0] pc, base, offset, a, b;
   logic [2:0]  opcode;
   logic [31:0] pc_plus4, branch_target, alu_out;
   logic        zero, overflow;

   typedef struct {
      logic [31:0] pcp4;
      logic [31:0] bt;
      logic [31:0] alu;
      logic        ovf;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   ex_arith_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .en(en), .pc(pc), .base(base), .offset(offset),
      .a(a), .b(b), .opcode(opcode), .pc_plus4(pc_plus4),
      .branch_target(branch_target), .alu_out(alu_out), .zero(zero),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: plain wide arithmetic on the instruction semantics.
   function automatic exp_t model(input logic [31:0] p, bs, of, aa, bb, input logic [2:0] op);
      exp_t   m;
      longint sa, sb, r;
      longint unsigned u;
      sa = longint'($signed(aa));
      sb = longint'($signed(bb));
      u = longint'(p) + 4;
      m.pcp4 = u[31:0];
      u = longint'(bs) + longint'(of) * 4;
      m.bt = u[31:0];
      m.ovf = 1'b0;
      m.alu = 32'h0;
      case (op)
         3'd0: m.alu = aa & bb;
         3'd1: m.alu = aa | bb;
         3'd2: begin
            r = sa + sb;
            m.alu = r[31:0];
            m.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
         end
         3'd3: m.alu = aa ^ bb;
         3'd4: m.alu = ~(aa | bb);
         3'd5: m.alu = 32'h0;
         3'd6: begin
            r = sa - sb;
            m.alu = r[31:0];
            m.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
         end
         default: m.alu = (sa < sb) ? 32'd1 : 32'd0;
      endcase
      return m;
   endfunction

   // Drive one cycle of inputs at the falling edge; queue the expectation if it will load.
   task automatic drive(input logic [31:0] p, bs, of, aa, bb, input logic [2:0] op, input logic e);
      @(negedge clk);
      pc = p; base = bs; offset = of; a = aa; b = bb; opcode = op; en = e;
      if (e && rst) q.push_back(model(p, bs, of, aa, bb, op));
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'hFFFF_FFFF;
         5: return 32'hFFFF_FFFC;
         default: return $urandom;
      endcase
   endfunction

   // Monitor: track what the outputs should hold, compare after every rising edge.
   initial begin
      exp_t cur;
      cur = '{pcp4: 32'h0, bt: 32'h0, alu: 32'h0, ovf: 1'b0};
      forever begin
         @(posedge clk);
         if (rst !== 1'b1) begin
            cur = '{pcp4: 32'h0, bt: 32'h0, alu: 32'h0, ovf: 1'b0};
         end else if (en === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL scoreboard: got empty queue expected an entry at %0t", $time);
            end else begin
               cur = q.pop_front();
            end
         end
         #1;
         chk("pc_plus4", pc_plus4, cur.pcp4);
         chk("branch_target", branch_target, cur.bt);
         chk("alu_out", alu_out, cur.alu);
         chk("overflow", {31'b0, overflow}, {31'b0, cur.ovf});
         chk("zero", {31'b0, zero}, {31'b0, (cur.alu == 32'h0)});
      end
   end

   initial begin
      int wait_cyc;
      // Reset held with en=1 and arbitrary inputs: outputs must stay cleared.
      rst = 1'b0; en = 1'b1;
      pc = 32'h1234_5678; base = 32'hDEAD_BEEF; offset = 32'h5; a = 32'h7; b = 32'h9; opcode = 3'd2;
      repeat (4) @(negedge clk);
      rst = 1'b1; en = 1'b0;

      // PC / branch paths together with the logic sweep.
      drive(32'h0000_0000, 32'h10, 32'hFFFF_FFFF, 32'hF, 32'hF0, 3'd0, 1'b1);
      drive(32'hFFFF_FFFC, 32'h04, 32'h0000_0003, 32'hF, 32'hF0, 3'd1, 1'b1);
      drive(32'h0000_0100, 32'h00, 32'hC000_0001, 32'hF, 32'hF0, 3'd3, 1'b1);
      drive(32'h0000_0104, 32'h20, 32'h0000_0000, 32'hF, 32'hF0, 3'd4, 1'b1);
      drive(32'h0000_0108, 32'h20, 32'h1, 32'd5, 32'd3, 3'd2, 1'b1);
      drive(32'h0000_010C, 32'h20, 32'h1, 32'd5, 32'd5, 3'd6, 1'b1);
      // Overflow and SLT corners.
      drive(32'h0000_0110, 32'h20, 32'h1, 32'h7FFF_FFFF, 32'h1, 3'd2, 1'b1);
      drive(32'h0000_0114, 32'h20, 32'h1, 32'h8000_0000, 32'h1, 3'd6, 1'b1);
      drive(32'h0000_0118, 32'h20, 32'h1, 32'h8000_0000, 32'h1, 3'd7, 1'b1);
      drive(32'h0000_011C, 32'h20, 32'h1, 32'h1, 32'hFFFF_FFFF, 3'd7, 1'b1);
      drive(32'h0000_0120, 32'h20, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 3'd7, 1'b1);
      drive(32'h0000_0124, 32'h20, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd5, 1'b1);
      drive(32'h0000_0128, 32'h20, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 3'd2, 1'b1);

      // Enable hold: load, scramble inputs with en=0 for 3 cycles, then reload.
      drive(32'h0000_4000, 32'h100, 32'h8, 32'h1111_0000, 32'h0000_2222, 3'd1, 1'b1);
      repeat (3) drive($urandom, $urandom, $urandom, $urandom, $urandom, 3'($urandom_range(0, 7)), 1'b0);
      drive(32'h0000_5000, 32'h200, 32'h4, 32'd9, 32'd4, 3'd6, 1'b1);

      // Async assert between edges clears outputs immediately.
      drive(32'h0000_6000, 32'h300, 32'h2, 32'hAAAA_0000, 32'h0000_5555, 3'd3, 1'b1);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("async_pc_plus4", pc_plus4, 32'h0);
      chk("async_branch_target", branch_target, 32'h0);
      chk("async_alu_out", alu_out, 32'h0);
      chk("async_overflow", {31'b0, overflow}, 32'h0);
      chk("async_zero", {31'b0, zero}, 32'h1);
      @(negedge clk);
      rst = 1'b1; en = 1'b0;

      // First enabled edge after reset release loads fresh values.
      drive(32'h0000_7000, 32'h400, 32'h3, 32'h8000_0000, 32'h8000_0000, 3'd2, 1'b1);

      // Randomized traffic.
      for (int i = 0; i < 400; i++)
         drive(pick(), pick(), pick(), pick(), pick(), 3'($urandom_range(0, 7)),
               ($urandom_range(0, 3) != 0));
      drive(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0);

      // Drain the scoreboard with a bounded wait.
      wait_cyc = 0;
      while (q.size() != 0 && wait_cyc < 20) begin
         @(negedge clk);
         wait_cyc++;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_arith_unit.md
EX_ARITH_UNIT -- requirements
Module: ex_arith_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset (ports clk and rst).
REQ-002 Parameter WIDTH, default 32, SHALL set the datapath width; all behaviour below is specified for WIDTH=32.
REQ-003 clk  input  1  rising-edge clock for all output registers.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 en  input  1  register update enable.
REQ-006 pc  input  32  current program counter.
REQ-007 base  input  32  branch base (PC+4 of the instruction in execute).
REQ-008 offset  input  32  sign-extended immediate, word offset, not yet shifted.
REQ-009 a  input  32  ALU operand A.
REQ-010 b  input  32  ALU operand B, already muxed between register and immediate.
REQ-011 opcode  input  3  ALU operation select.
REQ-012 pc_plus4  output  32  registered pc+4.
REQ-013 branch_target  output  32  registered base+(offset<<2).
REQ-014 alu_out  output  32  registered ALU result.
REQ-015 zero  output  1  high when alu_out equals 0.
REQ-016 overflow  output  1  registered signed overflow flag.

Function
REQ-017 On each rising clk with rst high and en=1, all registered outputs SHALL load their new values; latency is exactly 1 cycle.
REQ-018 With en=0, all registered outputs SHALL hold their values.
REQ-019 pc_plus4 SHALL be computed as (pc+4) mod 2^32; the carry-out is discarded (0xFFFFFFFC -> 0x00000000).
REQ-020 branch_target SHALL be computed as (base + {offset[29:0],2'b00}) mod 2^32; offset[31:30] are dropped and the carry-out is discarded.
REQ-021 opcode 000 SHALL produce a AND b.
REQ-022 opcode 001 SHALL produce a OR b.
REQ-023 opcode 010 SHALL produce a+b mod 2^32.
REQ-024 opcode 011 SHALL produce a XOR b.
REQ-025 opcode 100 SHALL produce NOR(a,b).
REQ-026 opcode 101 SHALL produce 0.
REQ-027 opcode 110 SHALL produce a-b mod 2^32.
REQ-028 opcode 111 SHALL produce 1 when signed a < signed b, else 0 (SLT).
REQ-029 overflow SHALL capture signed overflow for ADD (operands share a sign, result sign differs) and SUB (operands differ in sign, result sign differs from a).
REQ-030 overflow SHALL capture 0 for all other opcodes.
REQ-031 zero SHALL be combinationally derived from the registered alu_out and SHALL NOT be separately registered.
REQ-032 SLT SHALL use the true signed comparison and SHALL be correct even when a-b overflows.
REQ-033 Inputs SHALL be sampled only at the clock edge; input glitches between edges SHALL have no effect on outputs.

Reset
REQ-034 While rst=0, pc_plus4, branch_target, alu_out and overflow SHALL be 0 and zero SHALL be 1.
REQ-035 rst assertion SHALL clear outputs immediately, without waiting for clk, including mid-operation.
REQ-036 After rst deasserts, the first rising clk with en=1 SHALL load fresh values.
REQ-037 If rst=0 coincides with a clock edge, reset SHALL win.

Verification
REQ-038 Reset: rst=0 with en=1 and arbitrary inputs -> all registered outputs 0, zero=1; an async assert between edges clears immediately.
REQ-039 PC path: pc=0x00000000 -> pc_plus4=0x00000004; pc=0xFFFFFFFC -> pc_plus4=0x00000000, one cycle later.
REQ-040 Branch path: base=0x00000010, offset=0xFFFFFFFF -> branch_target=0x0000000C; base=0x00000004, offset=0x00000003 -> 0x00000010.
REQ-041 ALU logic/arith sweep:
- a=0x0000000F, b=0x000000F0: AND=0, zero=1; OR=0x000000FF; XOR=0x000000FF; NOR=0xFFFFFF00.
- ADD 5+3=8; SUB 5-5=0, zero=1.
REQ-042 Overflow/SLT:
- ADD 0x7FFFFFFF+1 -> 0x80000000, overflow=1.
- SUB 0x80000000-1 -> overflow=1.
- SLT a=0x80000000, b=0x00000001 -> 1; SLT a=1, b=0xFFFFFFFF -> 0.
REQ-043 Enable hold: load values with en=1, then change every input with en=0 for 3 cycles -> outputs unchanged; set en=1 -> new values appear after 1 cycle.
